parallel_to_serial: RTL and testbench

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/parallel_to_serial.sv | 155 +++++++++++++++
 tb/tb_parallel_to_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: byte-to-bit serializer, MSB first, with a guaranteed
// idle gap of GAP_CYCLES cycles (dout_valid low) after every byte so a
// downstream 8-bit collector can realign on the low gap.
// Optional feature: define P2S_HOLD_BUF_EN to add a one-byte holding buffer
// that lets the next byte be accepted while the current one is shifting,
// giving back-to-back bytes spaced exactly 8+GAP_CYCLES cycles apart.
module parallel_to_serial #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_parallel,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout_serial,
    output logic       dout_valid,
    output logic       busy
);

    generate
        if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
            $error("parallel_to_serial: GAP_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [3:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic [7:0] shreg;      // remaining bits, next one in bit 7
    logic       armed;      // low during reset, high from the first edge after release
    logic       xfer;
    logic       gap_end;
    logic       load_en;
    logic [7:0] load_data;

`ifdef P2S_HOLD_BUF_EN
    logic       buf_full;
    logic [7:0] buf_data;
    logic       buf_cap;

    // Accept in IDLE, or while busy as long as the holding buffer is free
    assign din_ready = armed & ((state == IDLE) | ~buf_full);
`else
    // Without a buffer the block only takes a byte when fully idle
    assign din_ready = armed & (state == IDLE);
`endif

    assign xfer    = din_valid & din_ready;
    assign gap_end = (state == GAP) && (gap_cnt == GAP_LAST);

    // Choose whether a byte starts shifting at this edge, and which byte
    always_comb begin
        load_en   = 1'b0;
        load_data = din_parallel;
        if (state == IDLE) begin
            load_en = xfer;
        end else if (gap_end) begin
`ifdef P2S_HOLD_BUF_EN
            // Buffered byte wins; a byte arriving exactly at gap end with an
            // empty buffer goes straight to the shifter instead of being lost
            if (buf_full) begin
                load_en   = 1'b1;
                load_data = buf_data;
            end else begin
                load_en = xfer;
            end
`else
            load_en = 1'b0;
`endif
        end
    end

`ifdef P2S_HOLD_BUF_EN
    assign buf_cap = xfer & (state != IDLE) & ~load_en;

    // Holding buffer: filled while busy, drained when the gap ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
        end else if (buf_cap) begin
            buf_full <= 1'b1;
            buf_data <= din_parallel;
        end else if (gap_end && buf_full) begin
            buf_full <= 1'b0;
        end
    end
`endif

    // Main FSM with registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            gap_cnt     <= 4'd0;
            shreg       <= 8'h00;
            armed       <= 1'b0;
            dout_serial <= 1'b0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (load_en) begin
                // First bit goes out on the cycle right after the load
                state       <= SHIFT;
                bit_cnt     <= 4'd0;
                gap_cnt     <= 4'd0;
                shreg       <= {load_data[6:0], 1'b0};
                dout_serial <= load_data[7];
                dout_valid  <= 1'b1;
                busy        <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        if (bit_cnt == 4'd7) begin
                            state       <= GAP;
                            gap_cnt     <= 4'd0;
                            dout_serial <= 1'b0;
                            dout_valid  <= 1'b0;
                        end else begin
                            bit_cnt     <= bit_cnt + 4'd1;
                            dout_serial <= shreg[7];
                            shreg       <= {shreg[6:0], 1'b0};
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= 4'd0;
                            gap_cnt <= 4'd0;
                            busy    <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        dout_serial <= 1'b0;
                        dout_valid  <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: two instances (GAP_CYCLES 1 and 3) share the
// same stimulus; a timeline model (byte start cycle + fixed durations) predicts
// every output each cycle, and a downstream 8-bit collector is scored against
// the bytes the model says were fully emitted.
module tb_parallel_to_serial;

`ifdef P2S_HOLD_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_parallel = 8'h00;
    logic       din_valid = 1'b0;
    logic       rdy [2];
    logic       ser [2];
    logic       vld [2];
    logic       bsy [2];

    parallel_to_serial #(.GAP_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .din_parallel(din_parallel), .din_valid(din_valid),
        .din_ready(rdy[0]), .dout_serial(ser[0]), .dout_valid(vld[0]), .busy(bsy[0])
    );

    parallel_to_serial #(.GAP_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .din_parallel(din_parallel), .din_valid(din_valid),
        .din_ready(rdy[1]), .dout_serial(ser[1]), .dout_valid(vld[1]), .busy(bsy[1])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Timeline model: a byte occupies cycles start .. start+7 for bits and
    // start+8 .. start+8+gap-1 for the idle gap.
    int         gapv [2] = '{1, 3};
    bit         have_cur [2];
    bit         have_buf [2];
    bit         armed [2];
    logic [7:0] cur_b [2];
    logic [7:0] buf_b [2];
    int         start [2];
    bit         acc [2];
    logic [7:0] exp_q [2][$];

    // Downstream collector
    int         ccnt [2];
    logic [7:0] csh [2];
    logic [7:0] got_q [2][$];

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
        end
    endtask

    function automatic bit m_rdy(input int i);
        return armed[i] && (!have_cur[i] || (BUF && !have_buf[i]));
    endfunction

    function automatic bit m_vld(input int i);
        return have_cur[i] && (cyc - start[i]) < 8;
    endfunction

    function automatic logic m_bit(input int i);
        logic [7:0] b;
        b = cur_b[i];
        return m_vld(i) ? b[7 - (cyc - start[i])] : 1'b0;
    endfunction

    task automatic m_clear(input int i);
        have_cur[i] = 1'b0;
        have_buf[i] = 1'b0;
        armed[i]    = 1'b0;
    endtask

    task automatic m_step(input int i, input bit x);
        if (rst) begin
            m_clear(i);
        end else begin
            if (have_cur[i] && cyc == start[i] + 8 + gapv[i]) begin
                if (have_buf[i]) begin
                    cur_b[i]    = buf_b[i];
                    start[i]    = cyc;
                    have_buf[i] = 1'b0;
                end else begin
                    have_cur[i] = 1'b0;
                end
            end
            if (x) begin
                if (!have_cur[i]) begin
                    cur_b[i]    = din_parallel;
                    start[i]    = cyc;
                    have_cur[i] = 1'b1;
                end else begin
                    buf_b[i]    = din_parallel;
                    have_buf[i] = 1'b1;
                end
            end
            armed[i] = 1'b1;
            if (have_cur[i] && cyc - start[i] == 7) exp_q[i].push_back(cur_b[i]);
        end
    endtask

    task automatic check_outputs(input int i);
        chk("dout_valid",  i, 32'(vld[i]), 32'(m_vld(i)));
        chk("dout_serial", i, 32'(ser[i]), 32'(m_bit(i)));
        chk("busy",        i, 32'(bsy[i]), 32'(have_cur[i]));
        chk("din_ready",   i, 32'(rdy[i]), 32'(m_rdy(i)));
    endtask

    task automatic collect(input int i);
        if (vld[i] === 1'b1) begin
            csh[i] = {csh[i][6:0], ser[i]};
            ccnt[i]++;
            if (ccnt[i] == 8) begin
                got_q[i].push_back(csh[i]);
                ccnt[i] = 0;
            end
        end else begin
            ccnt[i] = 0;
        end
    endtask

    // One clock: decide transfers from the model's ready, advance, check at +1
    task automatic tick();
        bit x [2];
        for (int i = 0; i < 2; i++) x[i] = din_valid && m_rdy(i) && !rst;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_step(i, x[i]);
            acc[i] = x[i];
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check_outputs(i);
            collect(i);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Hold a byte on the input until instance 'inst' takes it (bounded)
    task automatic offer(input logic [7:0] b, input int inst);
        din_parallel = b;
        din_valid    = 1'b1;
        acc[inst]    = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (acc[inst]) break;
        end
        chk("offer_accepted", inst, 32'(acc[inst]), 32'd1);
    endtask

    // Asynchronous reset pulse asserted mid-cycle
    task automatic reset_pulse();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) m_clear(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_dout_valid", i, 32'(vld[i]), 32'd0);
            chk("rst_dout_serial", i, 32'(ser[i]), 32'd0);
            chk("rst_busy", i, 32'(bsy[i]), 32'd0);
            chk("rst_din_ready", i, 32'(rdy[i]), 32'd0);
        end
        ticks(2);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) chk("ready_after_rst", i, 32'(rdy[i]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_clear(i);
            start[i] = 0;
            ccnt[i]  = 0;
            csh[i]   = 8'h00;
        end
        // Reset state before any clock edge
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i);
        ticks(2);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) chk("ready_after_release", i, 32'(rdy[i]), 32'd1);

        // Single 0xA5
        offer(8'hA5, 0);
        din_valid = 1'b0;
        ticks(16);

        // 0x3C then 0xC3 offered continuously
        offer(8'h3C, 0);
        offer(8'hC3, 0);
        din_valid = 1'b0;
        ticks(30);

        // 0xFF with din_valid held high
        din_parallel = 8'hFF;
        din_valid    = 1'b1;
        ticks(40);
        din_valid = 1'b0;
        ticks(20);

        // Reset in the middle of 0x81
        offer(8'h81, 0);
        din_valid = 1'b0;
        ticks(4);
        reset_pulse();
        ticks(12);

        // 0x01 then 0x80 on the GAP_CYCLES=3 instance
        offer(8'h01, 1);
        offer(8'h80, 1);
        din_valid = 1'b0;
        ticks(30);

        // din_valid toggling while a byte is in flight
        offer(8'h5A, 0);
        for (int k = 0; k < 30; k++) begin
            din_valid    = (k % 2 == 0);
            din_parallel = 8'($urandom);
            tick();
        end
        din_valid = 1'b0;
        ticks(20);

        // Random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            din_valid    = ($urandom_range(0, 2) != 0);
            din_parallel = 8'($urandom);
            if ($urandom_range(0, 199) == 0) reset_pulse();
            else tick();
        end
        din_valid = 1'b0;
        ticks(40);

        // Collector output against the bytes the model says were emitted
        for (int i = 0; i < 2; i++) begin
            chk("byte_count", i, 32'(got_q[i].size()), 32'(exp_q[i].size()));
            for (int j = 0; j < exp_q[i].size() && j < got_q[i].size(); j++)
                chk("collected_byte", i, 32'(got_q[i][j]), 32'(exp_q[i][j]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
